// File: rtl/partial_sum_update_scheduler_pkg.sv
// Shared state codes and helpers for the SC polar decoder partial-sum scheduler.
// The state codes are one-hot-like values that the partial-sum calculator decodes directly.
package polar_ps_pkg;

  localparam int STATE_WIDTH = 10;

  // trailing_ones() works on ids up to this many bits; narrower ids are zero-extended
  localparam int PS_N_LOG_MAX = 16;
  localparam int PS_LAYER_WIDTH_MAX = $clog2(PS_N_LOG_MAX) + 1;

  typedef enum logic [STATE_WIDTH-1:0] {
    ST_IDLE          = 10'd1,
    ST_NEW_BIT_STORE = 10'd16,
    ST_READ          = 10'd32,
    ST_CAL_AND_STORE = 10'd64,
    ST_DONE          = 10'd128
  } ps_state_t;

  // Number of consecutive ones starting at the LSB: how many butterfly layers bit i completes.
  function automatic logic [PS_LAYER_WIDTH_MAX-1:0] trailing_ones(
    input logic [PS_N_LOG_MAX-1:0] value
  );
    logic [PS_LAYER_WIDTH_MAX-1:0] count;
    logic                          run;
    count = '0;
    run   = 1'b1;
    for (int b = 0; b < PS_N_LOG_MAX; b++) begin
      if (run && value[b]) begin
        count = count + PS_LAYER_WIDTH_MAX'(1);
      end else begin
        run = 1'b0;
      end
    end
    return count;
  endfunction

endpackage

// File: rtl/partial_sum_update_scheduler_if.sv
// Bit handshake plus calculator control bus of the partial-sum update scheduler.
// master = decoder top / decision unit side, slave = the scheduler itself.
interface partial_sum_update_scheduler_if #(
  parameter int N_LOG       = 10,
  parameter int LAYER_WIDTH = $clog2(N_LOG) + 1
);
  import polar_ps_pkg::*;

  logic                   start;
  logic                   bit_valid;
  logic                   bit_data;
  logic                   bit_ready;
  logic [STATE_WIDTH-1:0] state;
  logic                   new_bit_data;
  logic [N_LOG-1:0]       id_counter_value;
  logic [LAYER_WIDTH-1:0] layer;
  logic [N_LOG-2:0]       pair_index;
  logic                   busy;
  logic                   update_done;
  logic                   frame_done;

  modport master (
    output start,
    output bit_valid,
    output bit_data,
    input  bit_ready,
    input  state,
    input  new_bit_data,
    input  id_counter_value,
    input  layer,
    input  pair_index,
    input  busy,
    input  update_done,
    input  frame_done
  );

  modport slave (
    input  start,
    input  bit_valid,
    input  bit_data,
    output bit_ready,
    output state,
    output new_bit_data,
    output id_counter_value,
    output layer,
    output pair_index,
    output busy,
    output update_done,
    output frame_done
  );

endinterface

// File: rtl/partial_sum_update_scheduler_depth_calc.sv
// Update depth k for bit index id: trailing ones of id, forced to 0 for the last bit of the frame.
// Supports N_LOG up to PS_N_LOG_MAX.
module ps_update_depth_calc
  import polar_ps_pkg::*;
#(
  parameter int N_LOG       = 10,
  parameter int LAYER_WIDTH = $clog2(N_LOG) + 1
) (
  input  logic [N_LOG-1:0]       id,
  output logic [LAYER_WIDTH-1:0] k
);

  logic [PS_N_LOG_MAX-1:0]       id_ext;
  logic [PS_LAYER_WIDTH_MAX-1:0] ones;
  logic                          last_bit;

  assign id_ext   = PS_N_LOG_MAX'(id);
  assign ones     = trailing_ones(id_ext);
  // bit N-1 closes the frame; its partial sums are never consumed
  assign last_bit = &id;
  assign k        = last_bit ? '0 : LAYER_WIDTH'(ones);

endmodule

// File: rtl/partial_sum_update_scheduler.sv
// Partial-sum update scheduler: accepts one decoded bit at a time and walks the
// butterfly layers / pairs it completes, driving the partial-sum calculator.
module partial_sum_update_scheduler
  import polar_ps_pkg::*;
#(
  parameter int N_LOG       = 10,
  parameter int LAYER_WIDTH = $clog2(N_LOG) + 1
) (
  input logic                          clk,
  input logic                          reset,
  partial_sum_update_scheduler_if.slave bus
);

  localparam logic [N_LOG-1:0] LAST_ID = '1;

  ps_state_t              state_reg, state_next;
  logic [N_LOG-1:0]       id_reg, id_next;
  logic [LAYER_WIDTH-1:0] layer_reg, layer_next;
  logic [N_LOG-2:0]       pair_reg, pair_next;
  logic                   new_bit_reg, new_bit_next;
  logic                   frame_active_reg, frame_active_next;

  logic [LAYER_WIDTH-1:0] depth;
  logic                   bit_ready;
  logic                   accept;
  logic [N_LOG-1:0]       pair_span;
  logic                   pair_more;
  logic                   layer_more;

  ps_update_depth_calc #(
    .N_LOG       (N_LOG),
    .LAYER_WIDTH (LAYER_WIDTH)
  ) u_depth (
    .id (id_reg),
    .k  (depth)
  );

  assign bit_ready = frame_active_reg && (state_reg == ST_IDLE) && !bus.start;
  assign accept    = bus.bit_valid && bit_ready;

  // layer l holds 2^l pairs; pair_span is zero-extended so the compare never wraps
  assign pair_span  = N_LOG'(1) << layer_reg;
  assign pair_more  = {1'b0, pair_reg} < (pair_span - N_LOG'(1));
  assign layer_more = (layer_reg + LAYER_WIDTH'(1)) < depth;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      id_reg           <= '0;
      layer_reg        <= '0;
      pair_reg         <= '0;
      new_bit_reg      <= 1'b0;
      frame_active_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      id_reg           <= id_next;
      layer_reg        <= layer_next;
      pair_reg         <= pair_next;
      new_bit_reg      <= new_bit_next;
      frame_active_reg <= frame_active_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    id_next           = id_reg;
    layer_next        = layer_reg;
    pair_next         = pair_reg;
    new_bit_next      = new_bit_reg;
    frame_active_next = frame_active_reg;

    case (state_reg)
      ST_IDLE: begin
        // start wins over a pending bit: bit_ready is masked while start is high
        if (bus.start) begin
          frame_active_next = 1'b1;
          id_next           = '0;
        end else if (accept) begin
          new_bit_next = bus.bit_data;
          state_next   = ST_NEW_BIT_STORE;
        end
      end

      ST_NEW_BIT_STORE: begin
        if (depth != '0) begin
          layer_next = '0;
          pair_next  = '0;
          state_next = ST_READ;
        end else begin
          state_next = ST_DONE;
        end
      end

      ST_READ: begin
        state_next = ST_CAL_AND_STORE;
      end

      ST_CAL_AND_STORE: begin
        if (pair_more) begin
          pair_next  = pair_reg + (N_LOG-1)'(1);
          state_next = ST_READ;
        end else if (layer_more) begin
          layer_next = layer_reg + LAYER_WIDTH'(1);
          pair_next  = '0;
          state_next = ST_READ;
        end else begin
          state_next = ST_DONE;
        end
      end

      ST_DONE: begin
        state_next = ST_IDLE;
        if (id_reg == LAST_ID) begin
          id_next           = '0;
          frame_active_next = 1'b0;
        end else begin
          id_next = id_reg + N_LOG'(1);
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign bus.bit_ready        = bit_ready;
  assign bus.state            = state_reg;
  assign bus.new_bit_data     = new_bit_reg;
  assign bus.id_counter_value = id_reg;
  assign bus.layer            = layer_reg;
  assign bus.pair_index       = pair_reg;
  assign bus.busy             = (state_reg != ST_IDLE);
  assign bus.update_done      = (state_reg == ST_DONE);
  assign bus.frame_done       = (state_reg == ST_DONE) && (id_reg == LAST_ID);

endmodule

// File: tb/tb_partial_sum_update_scheduler.sv
// Bench for partial_sum_update_scheduler at N_LOG=3: random bits and gaps checked per cycle
// against a per-bit expected trace built from the layer/pair walk rules.
module tb_partial_sum_update_scheduler;

  localparam int N_LOG       = 3;
  localparam int N           = 1 << N_LOG;
  localparam int LAYER_WIDTH = $clog2(N_LOG) + 1;

  localparam int S_IDLE = 1;
  localparam int S_NEW  = 16;
  localparam int S_READ = 32;
  localparam int S_CAL  = 64;
  localparam int S_DONE = 128;

  typedef struct {
    int st;
    int layer;
    int pair;
  } step_t;

  logic clk;
  logic reset;

  partial_sum_update_scheduler_if #(.N_LOG(N_LOG), .LAYER_WIDTH(LAYER_WIDTH)) bus ();

  partial_sum_update_scheduler #(.N_LOG(N_LOG), .LAYER_WIDTH(LAYER_WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_cmp;
  int    n_fail;
  int    model_id;
  bit    model_active;
  bit    model_bit;
  step_t trace[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  // layers completed by bit i = number of trailing ones of i; last bit needs none
  function automatic int depth_of(input int id);
    int k;
    k = 0;
    if (id == N - 1) return 0;
    while (((id >> k) & 1) == 1) k++;
    return k;
  endfunction

  task automatic build_trace(input int id);
    step_t s;
    trace.delete();
    s.st = S_NEW; s.layer = 0; s.pair = 0;
    trace.push_back(s);
    for (int l = 0; l < depth_of(id); l++) begin
      for (int p = 0; p < (1 << l); p++) begin
        s.layer = l; s.pair = p;
        s.st = S_READ; trace.push_back(s);
        s.st = S_CAL;  trace.push_back(s);
      end
    end
    s.st = S_DONE; s.layer = 0; s.pair = 0;
    trace.push_back(s);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cycle(input string where, input int st, input bit chk_lp,
                             input int layer, input int pair);
    check($sformatf("%s.state", where), bus.state, st);
    check($sformatf("%s.id", where), bus.id_counter_value, model_id);
    check($sformatf("%s.new_bit", where), bus.new_bit_data, model_bit);
    check($sformatf("%s.busy", where), bus.busy, st != S_IDLE);
    check($sformatf("%s.update_done", where), bus.update_done, st == S_DONE);
    check($sformatf("%s.frame_done", where), bus.frame_done, (st == S_DONE) && (model_id == N - 1));
    check($sformatf("%s.bit_ready", where), bus.bit_ready, (st == S_IDLE) && model_active);
    if (chk_lp) begin
      check($sformatf("%s.layer", where), bus.layer, layer);
      check($sformatf("%s.pair", where), bus.pair_index, pair);
    end
  endtask

  task automatic check_reset(input string where);
    check($sformatf("%s.state", where), bus.state, S_IDLE);
    check($sformatf("%s.id", where), bus.id_counter_value, 0);
    check($sformatf("%s.layer", where), bus.layer, 0);
    check($sformatf("%s.pair", where), bus.pair_index, 0);
    check($sformatf("%s.new_bit", where), bus.new_bit_data, 0);
    check($sformatf("%s.update_done", where), bus.update_done, 0);
    check($sformatf("%s.frame_done", where), bus.frame_done, 0);
    check($sformatf("%s.busy", where), bus.busy, 0);
    check($sformatf("%s.bit_ready", where), bus.bit_ready, 0);
  endtask

  task automatic idle_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      tick();
      check_cycle("idle", S_IDLE, 1'b0, 0, 0);
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    #1;
    check("start.bit_ready_masked", bus.bit_ready, 0);
    tick();
    bus.start = 1'b0;
    #1;
    model_active = 1'b1;
    model_id     = 0;
    check_cycle("after_start", S_IDLE, 1'b0, 0, 0);
  endtask

  // Offer one bit and follow it cycle by cycle; start_at/reset_at index into the trace (-1 = never).
  task automatic process_bit(input bit data, input int start_at, input int reset_at);
    int id;
    bit chk_lp;
    id = model_id;
    build_trace(id);
    check("pre.bit_ready", bus.bit_ready, 1);
    bus.bit_valid = 1'b1;
    bus.bit_data  = data;
    $display("bit id=%0d data=%0d depth=%0d done_at=t+%0d", id, data, depth_of(id), trace.size() + 1 - 1 + 1);
    for (int j = 0; j < trace.size(); j++) begin
      tick();
      bus.start = 1'b0;
      #1;
      if (j == 0) model_bit = data;
      chk_lp = (trace[j].st == S_READ) || (trace[j].st == S_CAL);
      check_cycle("bit", trace[j].st, chk_lp, trace[j].layer, trace[j].pair);
      if (j == reset_at) begin
        reset         = 1'b1;
        bus.bit_valid = 1'b0;
        #1;
        model_id     = 0;
        model_active = 1'b0;
        model_bit    = 1'b0;
        check_reset("midreset");
        tick();
        reset = 1'b0;
        #1;
        check_cycle("post_reset", S_IDLE, 1'b0, 0, 0);
        return;
      end
      if (j == start_at) bus.start = 1'b1;
    end
    if (id == N - 1) begin
      model_id     = 0;
      model_active = 1'b0;
    end else begin
      model_id = id + 1;
    end
    tick();
    bus.start = 1'b0;
    #1;
    check_cycle("bit.idle", S_IDLE, 1'b0, 0, 0);
  endtask

  initial begin
    n_cmp         = 0;
    n_fail        = 0;
    model_id      = 0;
    model_active  = 1'b0;
    model_bit     = 1'b0;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.bit_valid = 1'b0;
    bus.bit_data  = 1'b0;

    repeat (3) tick();
    check_reset("reset");
    reset = 1'b0;
    idle_cycles(2);

    // frame 1: bit_valid held high, back-to-back bits 0..7
    pulse_start();
    for (int i = 0; i < N; i++) process_bit(1'($urandom_range(0, 1)), -1, -1);
    idle_cycles(3);
    bus.bit_valid = 1'b0;

    // frame 2: random gaps, stray start pulses while busy, restart at id 5, reset in READ of id 3
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      bus.bit_valid = 1'b0;
      idle_cycles($urandom_range(0, 2));
      process_bit(1'($urandom_range(0, 1)), $urandom_range(0, 7), -1);
    end
    bus.bit_valid = 1'b0;
    idle_cycles(1);
    pulse_start();
    for (int i = 0; i < 4; i++) process_bit(1'($urandom_range(0, 1)), -1, (i == 3) ? 1 : -1);
    bus.bit_valid = 1'b1;
    idle_cycles(2);
    bus.bit_valid = 1'b0;

    // frame 3: fully random gaps and start pulses
    pulse_start();
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        bus.bit_valid = 1'b0;
        idle_cycles($urandom_range(1, 3));
      end
      process_bit(1'($urandom_range(0, 1)), $urandom_range(0, 15), -1);
    end
    bus.bit_valid = 1'b0;
    idle_cycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
